fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of the synchronous program ROM. Owns the program counter, drives the ROM address and chip-select, captures the ROM's registered output one cycle later, and presents a word-aligned instruction plus its PC to decode over a valid/ready handshake. Absorbs decode back-pressure with a 2-entry buffer and supports branch/jump redirect with in-flight discard.

---
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues reads to the synchronous program ROM,
// captures the registered ROM word one cycle later and hands {pc, inst} to decode
// through a 2-entry buffer. Supports redirect with in-flight discard and a sticky
// fault on a misaligned redirect target.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] rom_address,
    output logic        rom_cs,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_fault
);

    logic        run_q;
    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        fault_q, fault_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] e0_pc_q, e0_pc_d, e0_inst_q, e0_inst_d;
    logic [31:0] e1_pc_q, e1_pc_d, e1_inst_q, e1_inst_d;

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  credit;
    logic [1:0]  count_after_pop;

    // Handshake, issue credit and ROM request; redirect gates both paths combinationally.
    always_comb begin
        inst_valid  = (count_q != 2'd0) && !redirect_valid && !fault_q;
        pop         = inst_valid && inst_ready;
        push        = pend_q && !redirect_valid && !fault_q;
        // Entries held plus the one in flight, less the one leaving, must leave room.
        credit      = {1'b0, count_q} + {2'b00, pend_q} - {2'b00, pop};
        issue       = run_q && !fault_q && !redirect_valid && (credit < 3'd2);
        rom_cs      = issue;
        rom_address = pc_q;
        inst        = e0_inst_q;
        inst_pc     = e0_pc_q;
        fetch_fault = fault_q;
    end

    // Next-state: PC advance, in-flight tracking, buffer shift/insert, redirect flush.
    always_comb begin
        pc_d       = pc_q;
        pend_d     = 1'b0;
        pend_pc_d  = pend_pc_q;
        fault_d    = fault_q;
        e0_pc_d    = e0_pc_q;
        e0_inst_d  = e0_inst_q;
        e1_pc_d    = e1_pc_q;
        e1_inst_d  = e1_inst_q;

        if (issue) begin
            pend_d    = 1'b1;
            pend_pc_d = pc_q;
            pc_d      = pc_q + 32'd4;
        end

        // Head always lives in entry 0; a pop shifts entry 1 down before any insert.
        count_after_pop = count_q - {1'b0, pop};
        if (pop) begin
            e0_pc_d   = e1_pc_q;
            e0_inst_d = e1_inst_q;
        end
        if (push) begin
            if (count_after_pop == 2'd0) begin
                e0_pc_d   = pend_pc_q;
                e0_inst_d = rom_data;
            end else begin
                e1_pc_d   = pend_pc_q;
                e1_inst_d = rom_data;
            end
        end
        count_d = count_after_pop + {1'b0, push};

        // Once faulted, redirects are ignored until reset.
        if (redirect_valid && !fault_q) begin
            count_d = 2'd0;
            pend_d  = 1'b0;
            pc_d    = redirect_pc;
            fault_d = (redirect_pc[1:0] != 2'b00);
        end
    end

    // State registers; asynchronous reset clears everything, dropping any in-flight read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q     <= 1'b0;
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= 32'd0;
            fault_q   <= 1'b0;
            count_q   <= 2'd0;
            e0_pc_q   <= 32'd0;
            e0_inst_q <= 32'd0;
            e1_pc_q   <= 32'd0;
            e1_inst_q <= 32'd0;
        end else begin
            run_q     <= 1'b1;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            fault_q   <= fault_d;
            count_q   <= count_d;
            e0_pc_q   <= e0_pc_d;
            e0_inst_q <= e0_inst_d;
            e1_pc_q   <= e1_pc_d;
            e1_inst_q <= e1_inst_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural ROM plus a stream scoreboard that predicts the
// ordered sequence of delivered PCs and issued ROM addresses from redirects alone.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rom_address;
    logic        rom_cs;
    logic [31:0] rom_data = 32'd0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] exp_pc;
    logic [31:0] exp_issue;
    logic        fault_exp;
    int          delivered;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .rom_address    (rom_address),
        .rom_cs         (rom_cs),
        .rom_data       (rom_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hA000_0000 + (a >> 2);
    endfunction

    // Synchronous ROM: registered output, held while not selected.
    always @(posedge clk) begin
        if (rom_cs) rom_data <= word(rom_address);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_pc    = RESET_PC;
        exp_issue = RESET_PC;
        fault_exp = 1'b0;
    endtask

    // Scoreboard for the current cycle; called mid-cycle with inputs stable.
    task automatic observe();
        chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, fault_exp});
        if (fault_exp || redirect_valid) begin
            chk("valid_blocked", {31'd0, inst_valid}, 32'd0);
            chk("cs_blocked", {31'd0, rom_cs}, 32'd0);
        end
        if (rom_cs) begin
            chk("rom_address", rom_address, exp_issue);
            exp_issue = exp_issue + 32'd4;
        end
        if (inst_valid) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst", inst, word(exp_pc));
            if (inst_ready) begin
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
        end
        if (redirect_valid && !fault_exp) begin
            exp_pc    = redirect_pc;
            exp_issue = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) fault_exp = 1'b1;
        end
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic adv();
        observe();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    // Assert reset mid-cycle, check outputs at once, then release so the next
    // interval is cycle 0.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_cs", {31'd0, rom_cs}, 32'd0);
        chk("rst_addr", rom_address, RESET_PC);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Cycles 0..3 after release with ready high: first issue in 1, first valid in 3.
    task automatic startup();
        logic [3:0] cs_tab;
        logic [3:0] v_tab;
        cs_tab = 4'b1110;
        v_tab  = 4'b1000;
        inst_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("start_cs", {31'd0, rom_cs}, {31'd0, cs_tab[c]});
            chk("start_valid", {31'd0, inst_valid}, {31'd0, v_tab[c]});
            if (c == 3) chk("start_pc", inst_pc, RESET_PC);
            adv();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [31:0] wrap_tab [4];
        wrap_tab[0] = 32'hFFFF_FFF8;
        wrap_tab[1] = 32'hFFFF_FFFC;
        wrap_tab[2] = 32'h0000_0000;
        wrap_tab[3] = 32'h0000_0004;
        delivered      = 0;
        reset          = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        startup();                       // cycles 0..3

        step();                          // cycle 4
        inst_ready = 1'b0;               // cycles 5..14 stalled
        for (int c = 5; c < 15; c++) begin
            settle();
            if (c >= 8) begin
                chk("stall_cs", {31'd0, rom_cs}, 32'd0);
                chk("stall_valid", {31'd0, inst_valid}, 32'd1);
            end
            adv();
        end
        inst_ready = 1'b1;               // resume: no gaps
        for (int c = 0; c < 8; c++) begin
            settle();
            chk("resume_valid", {31'd0, inst_valid}, 32'd1);
            adv();
        end

        // Redirect with buffer full.
        inst_ready = 1'b0;
        repeat (3) step();
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        settle();
        chk("redir_cs", {31'd0, rom_cs}, 32'd1);
        chk("redir_addr", rom_address, 32'h0000_0100);
        adv();
        settle();
        chk("redir_gap", {31'd0, inst_valid}, 32'd0);
        adv();
        settle();
        chk("redir_valid", {31'd0, inst_valid}, 32'd1);
        chk("redir_pc", inst_pc, 32'h0000_0100);
        adv();
        repeat (3) step();

        // Redirect while streaming (read in flight).
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        repeat (6) step();

        // Wrap-around of the PC.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("wrap_valid", {31'd0, inst_valid}, 32'd1);
            chk("wrap_pc", inst_pc, wrap_tab[k]);
            adv();
        end

        // Randomized ready and aligned redirects against the scoreboard.
        delivered = 0;
        for (int c = 0; c < 400; c++) begin
            inst_ready     = ($urandom_range(3) != 0);
            redirect_valid = ($urandom_range(19) == 0);
            r              = $urandom;
            redirect_pc    = {r[31:2], 2'b00};
            step();
        end
        redirect_valid = 1'b0;
        chk("random_progress", {31'd0, delivered > 100}, 32'd1);

        // Misaligned redirect: sticky fault, later redirect ignored.
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            redirect_valid = (c == 10);
            redirect_pc    = 32'h0000_0300;
            step();
        end
        redirect_valid = 1'b0;
        settle();
        chk("fault_held", {31'd0, fetch_fault}, 32'd1);
        @(posedge clk);
        #1;
        do_reset();
        startup();
        repeat (4) step();

        // Reset with a full buffer and fetch activity pending.
        inst_ready = 1'b0;
        repeat (3) step();
        do_reset();
        startup();
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
